jtpopeye_objdma: RTL and testbench

//  Vertical-blank object DMA. On each VB rising edge it requests the main Z80 bus (busrq_n).

---
 rtl/jtpopeye_objdma.sv | 165 ++++++++++++++++
 tb/tb_jtpopeye_objdma.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_objdma.sv
`default_nettype none
// ============================================================================
//  Module   : jtpopeye_objdma
//  Purpose  : Vertical-blank object DMA from main Z80 RAM into the object
//             line buffer, with bus request/grant handshake and abort on
//             lost grant.
//  Revision : 1.0  initial release
// ============================================================================

module jtpopeye_objdma #(
  parameter int AW    = 10,
  parameter int RDLAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          VB,
  input  logic          busak_n,
  output logic          busrq_n,
  output logic          dma_cs,
  output logic [AW-1:0] AD_DMA,
  input  logic [7:0]    DD_DMA,
  output logic          obj_we,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_data,
  output logic          busy,
  output logic          done,
  output logic          abort
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_XFER  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_REL   = 3'd4
  } state_t;

  localparam logic [AW-1:0] c_last_addr = '1;
  localparam logic [AW-1:0] c_one       = {{(AW-1){1'b0}}, 1'b1};

  state_t          r_state, w_state_nx;
  logic            r_vbl;
  logic            w_vb_rise, w_issue, w_flush;
  logic            w_busrq_nx, w_dma_cs_nx, w_busy_nx, w_done_nx, w_abort_nx;
  logic [AW-1:0]   w_ad_nx;
  logic [RDLAT:1]  r_pv;
  logic [AW-1:0]   r_pa [1:RDLAT];

  assign w_vb_rise = VB & ~r_vbl;
  assign w_issue   = (r_state == ST_XFER) & ~busak_n;
  // Losing the grant mid-transfer discards everything still in flight.
  assign w_flush   = ((r_state == ST_XFER) | (r_state == ST_DRAIN)) & busak_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_vbl   <= 1'b0;
      busrq_n <= 1'b1;
      dma_cs  <= 1'b0;
      AD_DMA  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_vbl   <= VB;
      busrq_n <= w_busrq_nx;
      dma_cs  <= w_dma_cs_nx;
      AD_DMA  <= w_ad_nx;
      busy    <= w_busy_nx;
      done    <= w_done_nx;
      abort   <= w_abort_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_busrq_nx  = busrq_n;
    w_dma_cs_nx = dma_cs;
    w_ad_nx     = AD_DMA;
    w_busy_nx   = busy;
    w_done_nx   = 1'b0;
    w_abort_nx  = abort;
    case (r_state)
      ST_IDLE: begin
        if (w_vb_rise) begin
          w_abort_nx = 1'b0;
          if (enable) begin
            w_state_nx = ST_REQ;
            w_busrq_nx = 1'b0;
            w_busy_nx  = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (!busak_n) begin
          w_state_nx  = ST_XFER;
          w_dma_cs_nx = 1'b1;
          w_ad_nx     = '0;
        end
      end
      ST_XFER: begin
        if (busak_n) begin
          w_state_nx  = ST_REL;
          w_dma_cs_nx = 1'b0;
          w_abort_nx  = 1'b1;
        end else begin
          w_ad_nx = AD_DMA + c_one;
          if (AD_DMA == c_last_addr) w_state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (busak_n) begin
          w_state_nx  = ST_REL;
          w_dma_cs_nx = 1'b0;
          w_abort_nx  = 1'b1;
        end else if (r_pv == '0) begin
          w_state_nx = ST_REL;
        end
      end
      ST_REL: begin
        w_state_nx  = ST_IDLE;
        w_dma_cs_nx = 1'b0;
        w_busrq_nx  = 1'b1;
        w_busy_nx   = 1'b0;
        w_done_nx   = ~abort;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Issued address travels with a valid bit so the write lands with its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      for (int i = 1; i <= RDLAT; i++) r_pa[i] <= '0;
    end else begin
      r_pv[1] <= w_issue;
      r_pa[1] <= AD_DMA;
      for (int i = 2; i <= RDLAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
      end
      if (w_flush) r_pv <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obj_we   <= 1'b0;
      obj_addr <= '0;
      obj_data <= '0;
    end else begin
      obj_we <= r_pv[RDLAT] & ~w_flush;
      if (r_pv[RDLAT] && !w_flush) begin
        obj_addr <= r_pa[RDLAT];
        obj_data <= DD_DMA;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtpopeye_objdma.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtpopeye_objdma
//  Purpose  : Self-checking bench for jtpopeye_objdma with a 2-cycle RAM
//             model, a Z80 grant model and an object-write scoreboard.
//  Revision : 1.0  initial release
// ============================================================================

module tb_jtpopeye_objdma;

  logic       clk = 1'b0;
  logic       rst_n, enable, VB, busak_n, busrq_n, dma_cs;
  logic [9:0] AD_DMA, obj_addr;
  logic [7:0] DD_DMA, obj_data;
  logic       obj_we, busy, done, abort;

  jtpopeye_objdma #(.AW(10), .RDLAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .VB(VB), .busak_n(busak_n),
    .busrq_n(busrq_n), .dma_cs(dma_cs), .AD_DMA(AD_DMA), .DD_DMA(DD_DMA),
    .obj_we(obj_we), .obj_addr(obj_addr), .obj_data(obj_data),
    .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  // Main RAM: registered address, registered data, content addr^5A.
  logic [9:0] ram_a = '0;
  always @(posedge clk) begin
    ram_a  <= AD_DMA;
    DD_DMA <= ram_a[7:0] ^ 8'h5A;
  end

  typedef struct { logic [9:0] a; logic [7:0] d; } wr_t;
  typedef struct { bit en; int gd; int eb; int ed; } vec_t;

  wr_t sbq[$];
  wr_t exp_w;
  int  checks = 0, errors = 0;
  int  cyc = 0, n_we = 0, n_done = 0, n_rel = 0, wcnt = 0, gdelay = 5;
  int  first_we = -1, last_we = -1, dma_rise = -1, last_issue = -1, we_at_rel = 0;
  bit  hold_off = 0, prev_cs = 0, prev_rq = 1;
  vec_t vecs[4];

  always @(posedge clk) cyc++;

  // Output monitor, scoreboard pop, and Z80 bus-grant model.
  always @(negedge clk) begin
    if (obj_we) begin
      n_we++;
      last_we = cyc;
      if (first_we < 0) first_we = cyc;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h required none", obj_addr, obj_data);
      end else begin
        exp_w = sbq.pop_front();
        if (obj_addr !== exp_w.a || obj_data !== exp_w.d) begin
          errors++;
          $display("FAIL obj_write actual addr=%h data=%h required addr=%h data=%h",
                   obj_addr, obj_data, exp_w.a, exp_w.d);
        end
      end
    end
    if (done) n_done++;
    if (dma_cs && !prev_cs) dma_rise = cyc;
    prev_cs = dma_cs;
    if (dma_cs && AD_DMA == 10'h3FF) last_issue = cyc;
    if (busrq_n && !prev_rq) n_rel++;
    prev_rq = busrq_n;
    if (busrq_n) begin
      busak_n = 1'b1;
      wcnt    = 0;
    end else if (hold_off) begin
      if (!busak_n) begin
        busak_n   = 1'b1;
        we_at_rel = n_we;
      end
    end else if (busak_n) begin
      wcnt++;
      if (wcnt >= gdelay) busak_n = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic clear_stats();
    n_we = 0; n_done = 0; n_rel = 0;
    first_we = -1; last_we = -1; dma_rise = -1; last_issue = -1;
  endtask

  task automatic push_full();
    for (int i = 0; i < 1024; i++) begin
      wr_t w;
      w.a = 10'(i);
      w.d = 8'(i) ^ 8'h5A;
      sbq.push_back(w);
    end
  endtask

  task automatic pulse_vb();
    VB = 1'b1;
    tick();
    VB = 1'b0;
    tick();
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin
      tick();
      k++;
    end
    chk("done_timeout", int'(n_done != 0), 1);
    repeat (3) tick();
  endtask

  task automatic wait_we(input int n, input int budget);
    int k = 0;
    while (n_we < n && k < budget) begin
      tick();
      k++;
    end
    chk("write_count_timeout", int'(n_we >= n), 1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; VB = 1'b0; busak_n = 1'b1;
    repeat (3) tick();
    chk("rst_busrq_n", int'(busrq_n), 1);
    chk("rst_dma_cs",  int'(dma_cs), 0);
    chk("rst_ad_dma",  int'(AD_DMA), 0);
    chk("rst_obj",     int'({obj_we, obj_addr, obj_data}), 0);
    chk("rst_flags",   int'({busy, done, abort}), 0);
    rst_n = 1'b1;
    tick();

    // {enable at VB, grant delay, expected bytes, expected done pulses}
    vecs[0] = '{1'b1, 5,  1024, 1};
    vecs[1] = '{1'b0, 5,  0,    0};
    vecs[2] = '{1'b1, 1,  1024, 1};
    vecs[3] = '{1'b1, 40, 1024, 1};
    for (int v = 0; v < 4; v++) begin
      clear_stats();
      gdelay = vecs[v].gd;
      enable = vecs[v].en;
      if (vecs[v].en) push_full();
      pulse_vb();
      if (vecs[v].en) wait_done(2000);
      else begin
        repeat (10) chk("disabled_busrq_n", int'(busrq_n), 1);
        repeat (50) tick();
      end
      chk("vec_bytes",   n_we,   vecs[v].eb);
      chk("vec_done",    n_done, vecs[v].ed);
      chk("vec_busrq_n", int'(busrq_n), 1);
      chk("vec_busy",    int'(busy), 0);
      chk("vec_queue",   sbq.size(), 0);
      if (vecs[v].en) begin
        chk("first_we_latency", first_we - dma_rise, 3);
        chk("last_we_latency",  last_we - last_issue, 3);
        chk("hold_addr", int'(obj_addr), 10'h3FF);
        chk("hold_data", int'(obj_data), 8'hA5);
      end
      enable = 1'b1;
    end

    // Long grant wait with a second VB rise while requesting.
    clear_stats();
    gdelay = 200;
    push_full();
    pulse_vb();
    repeat (60) tick();
    chk("req_busrq_low", int'(busrq_n), 0);
    pulse_vb();
    repeat (60) tick();
    chk("req_still_low", int'(busrq_n), 0);
    wait_done(2500);
    repeat (50) tick();
    chk("single_bytes", n_we, 1024);
    chk("single_rel",   n_rel, 1);
    chk("single_done",  n_done, 1);
    chk("single_queue", sbq.size(), 0);

    // Grant lost after 100 bytes.
    clear_stats();
    gdelay = 3;
    push_full();
    pulse_vb();
    wait_we(100, 400);
    hold_off = 1'b1;
    repeat (10) tick();
    chk("abort_flag",   int'(abort), 1);
    chk("abort_done",   n_done, 0);
    chk("abort_busrq",  int'(busrq_n), 1);
    chk("abort_dma_cs", int'(dma_cs), 0);
    chk("abort_busy",   int'(busy), 0);
    chk("abort_tail",   int'(n_we - we_at_rel <= 2), 1);
    chk("abort_partial", int'(n_we < 1024), 1);
    sbq.delete();
    hold_off = 1'b0;
    clear_stats();
    push_full();
    pulse_vb();
    chk("abort_cleared", int'(abort), 0);
    wait_done(2000);
    chk("post_abort_bytes", n_we, 1024);
    chk("post_abort_done",  n_done, 1);
    chk("post_abort_queue", sbq.size(), 0);

    // Enable dropped mid-transfer.
    clear_stats();
    push_full();
    pulse_vb();
    wait_we(300, 600);
    enable = 1'b0;
    wait_done(2000);
    chk("en_drop_bytes", n_we, 1024);
    chk("en_drop_done",  n_done, 1);
    enable = 1'b1;

    // Reset asserted mid-transfer.
    clear_stats();
    push_full();
    pulse_vb();
    wait_we(500, 800);
    rst_n = 1'b0;
    #1;
    chk("midrst_busrq", int'(busrq_n), 1);
    chk("midrst_dma_cs", int'(dma_cs), 0);
    chk("midrst_obj_we", int'(obj_we), 0);
    chk("midrst_busy", int'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
    sbq.delete();
    repeat (5) tick();
    clear_stats();
    push_full();
    pulse_vb();
    wait_done(2000);
    chk("post_rst_bytes", n_we, 1024);
    chk("post_rst_done",  n_done, 1);
    chk("post_rst_queue", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
